// File: rtl/lane_packer.sv
// Packs single-byte lane-placed input beats into 32-bit words, first byte in [7:0].
// A word closes after four bytes or on in_last; a one-entry output register holds it.
module lane_packer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_lane,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_count,
  output logic             err_lane
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_count_q, out_count_d;
  logic             err_q, err_d;

  logic             in_fire;
  logic             complete;
  logic [7:0]       lane_byte;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] acc_ins;

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign complete  = in_fire && ((cnt_q == 2'd3) || in_last);

  always_comb begin
    lane_byte = '0;
    lane_mask = '0;
    unique case (in_lane)
      2'd0: begin lane_byte = in_data[7:0];   lane_mask = 32'h0000_00ff; end
      2'd1: begin lane_byte = in_data[15:8];  lane_mask = 32'h0000_ff00; end
      2'd2: begin lane_byte = in_data[23:16]; lane_mask = 32'h00ff_0000; end
      2'd3: begin lane_byte = in_data[31:24]; lane_mask = 32'hff00_0000; end
      default: ;
    endcase
  end

  // Accumulator with the incoming byte merged at the current fill position.
  always_comb begin
    acc_ins = acc_q;
    unique case (cnt_q)
      2'd0: acc_ins[7:0]   = lane_byte;
      2'd1: acc_ins[15:8]  = lane_byte;
      2'd2: acc_ins[23:16] = lane_byte;
      2'd3: acc_ins[31:24] = lane_byte;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    err_d = in_fire && |(in_data & ~lane_mask);
    if (in_fire) begin
      if (complete) begin
        cnt_d = 2'd0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        acc_d = acc_ins;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      StEmpty: begin
        if (complete) begin
          state_d     = StFull;
          out_data_d  = acc_ins;
          out_count_d = {1'b0, cnt_q} + 3'd1;
        end
      end
      StFull: begin
        // Completion here implies out_ready, since in_ready is low otherwise.
        if (complete) begin
          out_data_d  = acc_ins;
          out_count_d = {1'b0, cnt_q} + 3'd1;
        end else if (out_ready) begin
          state_d     = StEmpty;
          out_data_d  = '0;
          out_count_d = 3'd0;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      cnt_q       <= 2'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign err_lane  = err_q;

endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer: directed scenarios then random traffic, all checked against
// a queue-based model of byte collection and word delivery.
module tb_lane_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_lane;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        err_lane;

  always #5 clk = ~clk;

  lane_packer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_lane   (in_lane),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .err_lane  (err_lane)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
  } word_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  word_t      exp_q[$];
  logic [7:0] part_q[$];
  logic       exp_err = 1'b0;

  logic        d_rst       = 1'b1;
  logic        d_in_valid  = 1'b0;
  logic [31:0] d_in_data   = '0;
  logic [1:0]  d_in_lane   = '0;
  logic        d_in_last   = 1'b0;
  logic        d_out_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check outputs, apply staged inputs, then advance the reference model.
  task automatic cycle();
    logic       valid, ofire, ifire;
    logic [7:0] b;
    word_t      w;
    @(negedge clk);
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_eq("out_data", out_data, exp_q[0].data);
      check_eq("out_count", {29'b0, out_count}, {29'b0, exp_q[0].count});
    end else begin
      check_eq("out_count_idle", {29'b0, out_count}, 32'd0);
    end
    check_eq("err_lane", {31'b0, err_lane}, {31'b0, exp_err});

    rst       = d_rst;
    in_valid  = d_in_valid;
    in_data   = d_in_data;
    in_lane   = d_in_lane;
    in_last   = d_in_last;
    out_ready = d_out_ready;
    #1;
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || d_out_ready});

    if (d_rst) begin
      exp_q.delete();
      part_q.delete();
      exp_err = 1'b0;
    end else begin
      valid = exp_q.size() != 0;
      ofire = valid && d_out_ready;
      ifire = d_in_valid && (!valid || d_out_ready);
      if (ofire) void'(exp_q.pop_front());
      exp_err = ifire && ((d_in_data & ~(32'hff << (8 * d_in_lane))) != 0);
      if (ifire) begin
        b = 8'((d_in_data >> (8 * d_in_lane)) & 32'hff);
        part_q.push_back(b);
        if (part_q.size() == 4 || d_in_last) begin
          w.data  = '0;
          w.count = 3'(part_q.size());
          for (int i = 0; i < part_q.size(); i++) w.data = w.data | (32'(part_q[i]) << (8 * i));
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  endtask

  task automatic beat(input int lane, input logic [7:0] b, input logic last,
                      input logic [31:0] junk);
    d_in_valid = 1'b1;
    d_in_lane  = 2'(lane);
    d_in_data  = (32'(b) << (8 * lane)) | junk;
    d_in_last  = last;
    cycle();
  endtask

  task automatic idle();
    d_in_valid = 1'b0;
    d_in_last  = 1'b0;
    cycle();
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_lane = '0; in_last = 1'b0; out_ready = 1'b0;

    d_rst = 1'b1;
    idle();
    idle();
    post();
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_count", {29'b0, out_count}, 32'd0);
    check_eq("rst_err", {31'b0, err_lane}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    d_rst = 1'b0;

    // Full word with out_ready high.
    d_out_ready = 1'b1;
    beat(0, 8'h11, 1'b0, '0);
    beat(1, 8'h22, 1'b0, '0);
    beat(2, 8'h33, 1'b0, '0);
    beat(3, 8'h44, 1'b0, '0);
    post();
    check_eq("full_data", out_data, 32'h4433_2211);
    check_eq("full_count", {29'b0, out_count}, 32'd4);
    idle();
    post();
    check_eq("full_one_cycle", {31'b0, out_valid}, 32'd0);

    // Partial flush.
    beat(0, 8'hab, 1'b0, '0);
    beat(1, 8'hcd, 1'b1, '0);
    post();
    check_eq("partial_data", out_data, 32'h0000_cdab);
    check_eq("partial_count", {29'b0, out_count}, 32'd2);
    idle();

    // Backpressure: first word pending, next four beats stalled.
    d_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(i, 8'(i + 1), 1'b0, '0);
    for (int i = 0; i < 4; i++) beat(i, 8'(i + 5), 1'b0, '0);
    post();
    check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("bp_hold", out_data, 32'h0403_0201);
    d_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(i, 8'(i + 5), 1'b0, '0);
    post();
    check_eq("bp_second", out_data, 32'h0807_0605);
    idle();

    // Output handshake in the same cycle a new word completes.
    beat(0, 8'h5a, 1'b1, '0);
    beat(2, 8'ha5, 1'b1, '0);
    post();
    check_eq("simul_valid", {31'b0, out_valid}, 32'd1);
    check_eq("simul_data", out_data, 32'h0000_00a5);
    idle();
    idle();

    // Malformed beat still packs its byte.
    beat(0, 8'h12, 1'b0, 32'h00ff_0000);
    post();
    check_eq("malformed_err", {31'b0, err_lane}, 32'd1);
    beat(1, 8'h00, 1'b1, '0);
    post();
    check_eq("malformed_pulse", {31'b0, err_lane}, 32'd0);
    check_eq("malformed_data", out_data, 32'h0000_0012);
    idle();

    // Reset mid-word discards the partial bytes.
    beat(0, 8'hee, 1'b0, '0);
    beat(1, 8'hdd, 1'b0, '0);
    d_rst = 1'b1;
    idle();
    d_rst = 1'b0;
    for (int i = 0; i < 4; i++) beat(i, 8'(i + 1), 1'b0, '0);
    post();
    check_eq("rst_mid_data", out_data, 32'h0403_0201);
    check_eq("rst_mid_count", {29'b0, out_count}, 32'd4);
    idle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int          lane;
      logic [31:0] junk;
      lane        = int'($urandom_range(0, 3));
      junk        = ($urandom_range(0, 9) == 0) ? ($urandom() & ~(32'hff << (8 * lane))) : '0;
      d_rst       = ($urandom_range(0, 99) == 0);
      d_out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) beat(lane, 8'($urandom()), ($urandom_range(0, 4) == 0), junk);
      else idle();
    end
    d_rst = 1'b0;
    d_out_ready = 1'b1;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_packer.md
LANE_PACKER -- requirements
Module: lane_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-005 SHALL have port in_ready, output, 1 bit: input beat accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data, input, WIDTH bits: lane-placed word; exactly one byte lane carries payload, other lanes are zero.
REQ-007 SHALL have port in_lane, input, 2 bits: index of the payload lane (0 = [7:0], 1 = [15:8], 2 = [23:16], 3 = [31:24]).
REQ-008 SHALL have port in_last, input, 1 bit: this beat closes the current word, even if partial.
REQ-009 SHALL have port out_valid, output, 1 bit: packed word present.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, WIDTH bits: packed word, first byte in [7:0].
REQ-012 SHALL have port out_count, output, 3 bits: number of valid bytes in out_data (1..4).
REQ-013 SHALL have port err_lane, output, 1 bit: single-cycle pulse flagging a malformed input beat.

Function
REQ-014 SHALL extract the payload byte of an accepted beat as in_data[8*in_lane+7 : 8*in_lane].
REQ-015 SHALL hold an accumulator (32 bits) and a fill counter cnt (0..3) giving the next byte position.
REQ-016 SHALL write each accepted byte into accumulator byte position cnt, then increment cnt.
REQ-017 SHALL complete a word on an accepted beat when cnt==3 or in_last==1.
REQ-018 On completion, SHALL load the output register on the next edge with: out_data = accumulator including the new byte, unfilled upper bytes zero; out_count = cnt+1; out_valid = 1. cnt returns to 0 and the accumulator clears in the same cycle.
REQ-019 SHALL drive in_ready = !out_valid || out_ready, combinationally. This is the only combinational input-to-output path.
REQ-020 Output FSM SHALL have states EMPTY (out_valid=0) and FULL (out_valid=1):
- EMPTY -> FULL on completion.
- FULL -> EMPTY on an out handshake without completion in the same cycle.
- FULL -> FULL with new data on an out handshake and completion in the same cycle.
REQ-021 SHALL hold out_data and out_count stable while out_valid=1 and out_ready=0.
REQ-022 Latency SHALL be one cycle from the completing accepted beat to out_valid=1. Full throughput is one byte per cycle, and one word per 4 cycles with out_ready held high.
REQ-023 SHALL pulse err_lane=1 one cycle after an accepted beat whose non-selected lanes are not all zero. The byte SHALL still be packed normally.
REQ-024 SHALL ignore in_data, in_lane and in_last when no input handshake occurs.
REQ-025 SHALL hold out_count at 0 when out_valid=0.

Reset
REQ-026 On rst=1 at a clock edge, SHALL set out_valid=0, out_data=0, out_count=0, err_lane=0, cnt=0 and accumulator=0.
REQ-027 Reset mid-word SHALL discard partially packed bytes, with no output produced for them.
REQ-028 Reset SHALL take priority over any simultaneous handshake.
REQ-029 in_ready SHALL be 1 while rst is asserted and after reset release, since out_valid=0.

Verification
REQ-030 Full word: beats lanes 0,1,2,3 carrying 0x11, 0x2200, 0x330000, 0x44000000, out_ready=1 -> out_data=0x44332211, out_count=4, out_valid for 1 cycle.
REQ-031 Partial flush: beats 0xAB (lane 0), then 0xCD00 (lane 1) with in_last=1 -> out_data=0x0000CDAB, out_count=2.
REQ-032 Backpressure: out_ready=0 with a full word pending, then 4 more beats -> in_ready=0, out_data held. Raising out_ready -> first word taken, then second word delivered intact.
REQ-033 Simultaneous: out handshake in the same cycle a new word completes -> out_valid stays 1, out_data changes to the new word next cycle, no word lost or duplicated.
REQ-034 Malformed beat: in_lane=0, in_data=0x00FF0012 -> err_lane pulses one cycle, byte 0x12 packed.
REQ-035 Reset mid-word: 2 bytes accepted, rst pulse, then 4 beats 0x01..0x04 -> out_data=0x04030201, out_count=4, with no trace of the pre-reset bytes.
